button_event_arbiter: RTL and testbench
=======================================

// Module: button_event_arbiter
// PURPOSE
//  Collects single-cycle press pulses from NCH debouncer instances and serialises
//  them into one event stream (channel ID) with valid/ready handshake.
//  Round-robin fairness, one pending event per channel, saturating drop counter.
//  Sits between the debounced button inputs and the command/decode logic.
// PARAMETERS
//  NCH    4  number of button channels, 2..8
//  ID_W   2  width of evt_id; 2**ID_W >= NCH required
//  CNT_W  4  width of drop_cnt
// PORTS
//  clk         in   1      system clock
//  reset       in   1      asynchronous, active-low reset (0 = reset)
//  press_in    in   NCH    one-cycle press pulses, one bit per channel
//  evt_valid   out  1      evt_id holds an event
//  evt_id      out  ID_W   channel number of the offered event
//  evt_ready   in   1      consumer accepts the event this cycle
//  pending     out  NCH    per-channel pending flags (registered)
//  drop_cnt    out  CNT_W  count of cycles in which a press was lost, saturating
//  clear_drop  in   1      synchronous clear of drop_cnt
// BEHAVIOUR
//  Reset (async, reset=0): pending=0, evt_valid=0, evt_id=0, drop_cnt=0,
//   rr_last=NCH-1 (so channel 0 has first priority). Outputs go low immediately.
//   Any in-flight event is discarded.
//  Handshake: transfer when evt_valid & evt_ready. While evt_valid=1 and
//   evt_ready=0, evt_id is held stable. evt_valid never drops without a transfer.
//  Output stage free = ~evt_valid | evt_ready.
//  Each cycle with stage free and |pending:
//   - winner = first set pending bit searching rr_last+1, +2, ... (mod NCH).
//   - evt_id <= winner, evt_valid <= 1, rr_last <= winner.
//   - pending[winner] is cleared (the event moves into the output register).
//  Stage free and pending==0: evt_valid <= 0.
//  Throughput: one event per cycle with evt_ready held high.
//  Latency: press_in sampled at edge t -> pending set after t ->
//   evt_valid=1 after edge t+1 if the stage is free (2 cycles).
//  Per-channel pending update, channel i:
//   - press_in[i] & ~pending[i]             -> pending[i] <= 1
//   - press_in[i] & pending[i], not winner  -> press lost (drop)
//   - press_in[i] & i is winner same cycle  -> pending[i] stays 1 (new event kept)
//   - winner, no press                      -> pending[i] <= 0
//  drop_cnt: +1 per cycle with >=1 drop on any channel (not per channel).
//   Saturates at 2**CNT_W-1.
//   clear_drop: drop_cnt <= 0; if a drop occurs in the same cycle, drop_cnt <= 1.
//  press_in bits at index >= NCH are not present.
//  evt_id values >= NCH are never produced.
// TESTING
//  1 Reset low mid-offer (evt_valid=1) -> evt_valid=0, pending=0, drop_cnt=0
//    without a clock edge. After release, press ch2 -> evt_id=2 two cycles later.
//  2 press_in=4'b1111 in one cycle, evt_ready=1 -> evt_id sequence 0,1,2,3 on
//    consecutive cycles, then evt_valid=0.
//  3 Fairness: ch0 and ch1 re-pressed on every grant, evt_ready=1 -> IDs
//    alternate 0,1,0,1. Ch0 never granted twice in a row.
//  4 Backpressure: evt_ready=0, press ch3 -> evt_valid=1, evt_id=3 held 10 cycles.
//    Press ch3 again (pending) -> stored. Third press -> drop_cnt=1.
//    Raise evt_ready -> IDs 3,3.
//  5 Same-cycle grant and press on ch1 -> ch1 granted, pending[1] still 1,
//    second ch1 event follows, drop_cnt unchanged.
//  6 Force 20 drop cycles, CNT_W=4 -> drop_cnt stops at 15.
//    clear_drop with a simultaneous drop -> drop_cnt=1.

Source files
------------

// File: rtl/button_event_arbiter.sv
// Round-robin serialiser for debounced button press pulses.
// One pending event per channel, valid/ready output, saturating drop counter.
module button_event_arbiter #(
    parameter int NCH   = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   press_in,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_ready,
    output logic [NCH-1:0]   pending,
    output logic [CNT_W-1:0] drop_cnt,
    input  logic             clear_drop
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [ID_W-1:0] rr_last;
    logic [ID_W-1:0] win;
    logic            found;
    logic            free;
    logic            grant;
    logic [NCH-1:0]  win_oh;
    logic [NCH-1:0]  drop;
    logic [NCH-1:0]  pending_nxt;
    logic            any_drop;

    assign free  = ~evt_valid | evt_ready;
    assign grant = free & (|pending);

    // Search starts just after the last winner, so it has lowest priority.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NCH; k++) begin
            if (!found && pending[(int'(rr_last) + k) % NCH]) begin
                found = 1'b1;
                win   = ID_W'((int'(rr_last) + k) % NCH);
            end
        end
    end

    // A press arriving on the granted channel becomes its next event.
    always_comb begin
        win_oh      = '0;
        drop        = '0;
        pending_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            win_oh[i]      = grant && (win == ID_W'(i));
            drop[i]        = press_in[i] & pending[i] & ~win_oh[i];
            pending_nxt[i] = press_in[i] | (pending[i] & ~win_oh[i]);
        end
    end

    assign any_drop = |drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr_last   <= ID_W'(NCH - 1);
            drop_cnt  <= '0;
        end else begin
            pending <= pending_nxt;
            if (free) begin
                if (grant) begin
                    evt_valid <= 1'b1;
                    evt_id    <= win;
                    rr_last   <= win;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
            if (clear_drop) begin
                drop_cnt <= any_drop ? CNT_W'(1) : '0;
            end else if (any_drop && drop_cnt != CNT_MAX) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed self-checking bench for button_event_arbiter.
// Each scenario task drives stimulus and compares against hand-derived values.
module tb_button_event_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] press_in;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic [3:0] pending;
    logic [3:0] drop_cnt;
    logic       clear_drop;

    int errors;
    int checks;

    button_event_arbiter #(.NCH(4), .ID_W(2), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .press_in   (press_in),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .evt_ready  (evt_ready),
        .pending    (pending),
        .drop_cnt   (drop_cnt),
        .clear_drop (clear_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        press_in   = '0;
        evt_ready  = 1'b0;
        clear_drop = 1'b0;
        reset      = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (evt_valid !== 1'b0 || evt_id !== 2'd0 || pending !== 4'b0 || drop_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_state got v=%b id=%0d p=%b d=%0d want 0/0/0000/0",
                     evt_valid, evt_id, pending, drop_cnt);
        end
        // Build an in-flight offer plus a drop, then reset asynchronously.
        press_in = 4'b0010;
        tick();
        press_in = 4'b0000;
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset_offer got v=%b id=%0d want v=1 id=1", evt_valid, evt_id);
        end
        press_in = 4'b0010;
        tick();
        tick();
        press_in = 4'b0000;
        checks++;
        if (drop_cnt !== 4'd1 || pending !== 4'b0010) begin
            errors++;
            $display("FAIL pre_reset_drop got d=%0d p=%b want d=1 p=0010", drop_cnt, pending);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (evt_valid !== 1'b0 || pending !== 4'b0 || drop_cnt !== 4'd0 || evt_id !== 2'd0) begin
            errors++;
            $display("FAIL async_reset got v=%b id=%0d p=%b d=%0d want all 0",
                     evt_valid, evt_id, pending, drop_cnt);
        end
        #1;
        reset = 1'b1;
        tick();
        press_in = 4'b0100;
        tick();
        press_in = 4'b0000;
        checks++;
        if (evt_valid !== 1'b0 || pending !== 4'b0100) begin
            errors++;
            $display("FAIL post_reset_pend got v=%b p=%b want v=0 p=0100", evt_valid, pending);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2) begin
            errors++;
            $display("FAIL post_reset_evt got v=%b id=%0d want v=1 id=2", evt_valid, evt_id);
        end
        evt_ready = 1'b1;
        tick();
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_drain got v=%b want 0", evt_valid);
        end
    endtask

    task automatic test_all_press();
        logic [1:0] exp_id;
        do_reset();
        evt_ready = 1'b1;
        press_in  = 4'b1111;
        tick();
        press_in = 4'b0000;
        checks++;
        if (pending !== 4'b1111 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL all_pend got p=%b v=%b want 1111/0", pending, evt_valid);
        end
        for (int k = 0; k < 4; k++) begin
            exp_id = 2'(k);
            tick();
            checks++;
            if (evt_valid !== 1'b1 || evt_id !== exp_id) begin
                errors++;
                $display("FAIL all_seq[%0d] got v=%b id=%0d want v=1 id=%0d",
                         k, evt_valid, evt_id, exp_id);
            end
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0 || pending !== 4'b0) begin
            errors++;
            $display("FAIL all_done got v=%b p=%b want 0/0000", evt_valid, pending);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_id;
        do_reset();
        evt_ready = 1'b1;
        press_in  = 4'b0011;
        tick();
        for (int k = 0; k < 6; k++) begin
            exp_id   = 2'(k % 2);
            press_in = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            tick();
            checks++;
            if (evt_valid !== 1'b1 || evt_id !== exp_id || pending !== 4'b0011) begin
                errors++;
                $display("FAIL fair[%0d] got v=%b id=%0d p=%b want v=1 id=%0d p=0011",
                         k, evt_valid, evt_id, pending, exp_id);
            end
        end
        press_in = 4'b0000;
        tick();
        checks++;
        if (evt_id !== 2'd0 || pending !== 4'b0010 || drop_cnt !== 4'd0) begin
            errors++;
            $display("FAIL fair_tail0 got id=%0d p=%b d=%0d want 0/0010/0",
                     evt_id, pending, drop_cnt);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1 || pending !== 4'b0) begin
            errors++;
            $display("FAIL fair_tail1 got v=%b id=%0d p=%b want 1/1/0000",
                     evt_valid, evt_id, pending);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        press_in = 4'b1000;
        tick();
        press_in = 4'b0000;
        tick();
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
                errors++;
                bad++;
                $display("FAIL bp_hold[%0d] got v=%b id=%0d want v=1 id=3", k, evt_valid, evt_id);
            end
            tick();
        end
        press_in = 4'b1000;
        tick();
        checks++;
        if (pending !== 4'b1000 || drop_cnt !== 4'd0 || evt_id !== 2'd3) begin
            errors++;
            $display("FAIL bp_store got p=%b d=%0d id=%0d want 1000/0/3", pending, drop_cnt, evt_id);
        end
        tick();
        press_in = 4'b0000;
        checks++;
        if (drop_cnt !== 4'd1 || pending !== 4'b1000) begin
            errors++;
            $display("FAIL bp_drop got d=%0d p=%b want 1/1000", drop_cnt, pending);
        end
        evt_ready = 1'b1;
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd3 || pending !== 4'b0) begin
            errors++;
            $display("FAIL bp_second got v=%b id=%0d p=%b want 1/3/0000", evt_valid, evt_id, pending);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0 || drop_cnt !== 4'd1) begin
            errors++;
            $display("FAIL bp_done got v=%b d=%0d want 0/1", evt_valid, drop_cnt);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        evt_ready = 1'b1;
        press_in  = 4'b0010;
        tick();
        tick();
        press_in = 4'b0000;
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1 || pending !== 4'b0010 || drop_cnt !== 4'd0) begin
            errors++;
            $display("FAIL same_grant got v=%b id=%0d p=%b d=%0d want 1/1/0010/0",
                     evt_valid, evt_id, pending, drop_cnt);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1 || pending !== 4'b0) begin
            errors++;
            $display("FAIL same_second got v=%b id=%0d p=%b want 1/1/0000",
                     evt_valid, evt_id, pending);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0 || drop_cnt !== 4'd0) begin
            errors++;
            $display("FAIL same_done got v=%b d=%0d want 0/0", evt_valid, drop_cnt);
        end
    endtask

    task automatic test_drop_sat();
        do_reset();
        press_in = 4'b0001;
        tick();
        press_in = 4'b0000;
        tick();
        press_in = 4'b0001;
        tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1 || k == 15 || k == 20) begin
                checks++;
                if (drop_cnt !== ((k > 15) ? 4'd15 : 4'(k))) begin
                    errors++;
                    $display("FAIL drop_cnt[%0d] got %0d want %0d",
                             k, drop_cnt, (k > 15) ? 15 : k);
                end
            end
        end
        clear_drop = 1'b1;
        tick();
        checks++;
        if (drop_cnt !== 4'd1) begin
            errors++;
            $display("FAIL clear_with_drop got %0d want 1", drop_cnt);
        end
        press_in = 4'b0000;
        tick();
        clear_drop = 1'b0;
        checks++;
        if (drop_cnt !== 4'd0) begin
            errors++;
            $display("FAIL clear_plain got %0d want 0", drop_cnt);
        end
        press_in = 4'b0010;
        tick();
        press_in = 4'b0011;
        tick();
        press_in = 4'b0000;
        checks++;
        if (drop_cnt !== 4'd1 || pending !== 4'b0011) begin
            errors++;
            $display("FAIL drop_per_cycle got d=%0d p=%b want 1/0011", drop_cnt, pending);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset      = 1'b0;
        press_in   = '0;
        evt_ready  = 1'b0;
        clear_drop = 1'b0;
        tick();
        test_reset();
        test_all_press();
        test_fairness();
        test_backpressure();
        test_same_cycle();
        test_drop_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
